dcache_l2_port: RTL
===================

DCACHE_L2_PORT -- requirements
Module: dcache_l2_port

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per cache line (power of two, >=2); IDX_W = log2(LINE_WORDS).
REQ-002 SHALL have parameter L2_BUS_WIDTH, default 32, data width of every L2 beat; word addresses are 30 bits (ADDRESS_WIDTH-2, ADDRESS_WIDTH=32).
REQ-003 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port RSTN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port REQ_VALID  in  1  L1 miss request valid.
REQ-006 SHALL have port REQ_READY  out  1  block idle, request accepted on VALID&READY.
REQ-007 SHALL have port REQ_READ_ADDR  in  30  word address of line to fill.
REQ-008 SHALL have port REQ_WB  in  1  victim line dirty, write back before fill.
REQ-009 SHALL have port REQ_WB_ADDR  in  30  word address of victim line.
REQ-010 SHALL have port WB_INDEX  out  IDX_W  victim word index being written.
REQ-011 SHALL have port WB_DATA  in  L2_BUS_WIDTH  victim word at WB_INDEX, same-cycle lookup.
REQ-012 SHALL have port FILL_VALID  out  1  one-cycle strobe, FILL_DATA/FILL_INDEX valid.
REQ-013 SHALL have port FILL_INDEX  out  IDX_W  word index of filled word.
REQ-014 SHALL have port FILL_DATA  out  L2_BUS_WIDTH  filled word.
REQ-015 SHALL have port DONE  out  1  one-cycle pulse, transaction finished.
REQ-016 SHALL have L2 write ports WRITE_TO_L2_VALID_DATA out 1, WRITE_TO_L2_READY_DATA in 1, WRITE_ADDR_TO_L2_DATA out 30, DATA_TO_L2_DATA out L2_BUS_WIDTH, WRITE_CONTROL_TO_L2_DATA out 1 (last beat), WRITE_COMPLETE_DATA in 1 (L2 commit pulse).
REQ-017 SHALL have L2 read ports READ_ADDR_TO_L2_VALID_DATA out 1, READ_ADDR_TO_L2_READY_DATA in 1, READ_ADDR_TO_L2_DATA out 30, DATA_FROM_L2_READY_DATA out 1, DATA_FROM_L2_VALID_DATA in 1, DATA_FROM_L2_DATA in L2_BUS_WIDTH.

Function
REQ-018 SHALL implement states IDLE, WB_BEAT, WB_WAIT, RD_ADDR, RD_DATA, FIN with an IDX_W-bit word counter CNT.
REQ-019 IDLE: REQ_READY=1; on REQ_VALID latch both addresses with low IDX_W bits forced to 0, clear CNT, go WB_BEAT if REQ_WB else RD_ADDR; REQ_READY=0 in all other states, REQ_VALID ignored there.
REQ-020 WB_BEAT: WRITE_TO_L2_VALID_DATA=1, address=wb_base+CNT, WB_INDEX=CNT, DATA_TO_L2_DATA=WB_DATA, WRITE_CONTROL_TO_L2_DATA=1 only when CNT=LINE_WORDS-1; outputs held stable until WRITE_TO_L2_READY_DATA.
REQ-021 WB_BEAT handshake: CNT+1; on last beat CNT wraps to 0, go WB_WAIT.
REQ-022 WB_WAIT: wait for WRITE_COMPLETE_DATA=1, then RD_ADDR; WRITE_COMPLETE_DATA in any other state ignored.
REQ-023 RD_ADDR: READ_ADDR_TO_L2_VALID_DATA=1, address=rd_base+CNT, held until READ_ADDR_TO_L2_READY_DATA, then RD_DATA; one outstanding read maximum.
REQ-024 RD_DATA: DATA_FROM_L2_READY_DATA=1; on DATA_FROM_L2_VALID_DATA register FILL_DATA, FILL_INDEX=CNT, FILL_VALID=1 next cycle, CNT+1; go FIN after last word else RD_ADDR.
REQ-025 DATA_FROM_L2_VALID_DATA outside RD_DATA SHALL be ignored; DATA_FROM_L2_READY_DATA=0 there.
REQ-026 FIN: DONE=1 for exactly one cycle, coincident with final FILL_VALID, then IDLE; new request acceptable next cycle.
REQ-027 Address arithmetic SHALL be 30-bit modulo 2^30; base+CNT never carries out of the line.
REQ-028 Zero-wait L2 (ready always 1, read data valid in RD_DATA entry cycle), no WB: DONE SHALL be high in the cycle after the 2*LINE_WORDS-th rising edge following acceptance; WB adds LINE_WORDS+1+complete-wait cycles.

Reset
REQ-029 RSTN low SHALL asynchronously force IDLE, CNT=0, all outputs 0 except REQ_READY=1, aborting any transfer mid-beat; no DONE issued for the aborted request.
REQ-030 After RSTN release, first request SHALL be accepted on the first rising edge with REQ_VALID=1.

Verification
REQ-031 No WB, REQ_READ_ADDR=0x40, zero-wait L2 returning addr as data -> reads 0x40..0x43, FILL idx0..3 data 0x40..0x43, DONE 8 cycles after accept.
REQ-032 REQ_WB=1, WB_ADDR=0x13 (aligned 0x10), WB_DATA=0xA0+idx, READY low 2 cycles per beat -> writes 0x10..0x13 data 0xA0..0xA3, WRITE_CONTROL only on 0x13, reads start only after WRITE_COMPLETE_DATA.
REQ-033 READ_ADDR=0x3FFFFFFC -> addresses 0x3FFFFFFC..0x3FFFFFFF, no wrap into next line.
REQ-034 Spurious DATA_FROM_L2_VALID_DATA/WRITE_COMPLETE_DATA in IDLE and RD_ADDR, REQ_VALID during busy -> no FILL_VALID, no state change, second request not accepted.
REQ-035 RSTN low during RD_DATA word 2 -> outputs 0, REQ_READY=1 immediately, no DONE; next request completes normally.

Source files
------------

// File: rtl/dcache_l2_port.sv
// dcache_l2_port: moves one cache line between the L1 data cache and L2.
// An optional dirty victim is written back beat by beat and committed first,
// then the missing line is read one word per address/data round trip.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where valid and ready are both 1. The side asserting valid keeps valid and
// its payload stable until that edge. The request channel (req_valid /
// req_ready) follows the same rule, with req_ready high only while idle.
// write_complete_data is a one-cycle L2 commit pulse, honoured only while
// waiting for the write-back to commit.
module dcache_l2_port #(
    parameter int LINE_WORDS    = 4,
    parameter int L2_BUS_WIDTH  = 32,
    localparam int IDX_W        = $clog2(LINE_WORDS),
    localparam int ADDRESS_WIDTH = 32,
    localparam int ADDR_W       = ADDRESS_WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // L1 miss request
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_read_addr,
    input  logic                    req_wb,
    input  logic [ADDR_W-1:0]       req_wb_addr,
    // victim lookup and fill return
    output logic [IDX_W-1:0]        wb_index,
    input  logic [L2_BUS_WIDTH-1:0] wb_data,
    output logic                    fill_valid,
    output logic [IDX_W-1:0]        fill_index,
    output logic [L2_BUS_WIDTH-1:0] fill_data,
    output logic                    done,
    // L2 write channel
    output logic                    write_to_l2_valid_data,
    input  logic                    write_to_l2_ready_data,
    output logic [ADDR_W-1:0]       write_addr_to_l2_data,
    output logic [L2_BUS_WIDTH-1:0] data_to_l2_data,
    output logic                    write_control_to_l2_data,
    input  logic                    write_complete_data,
    // L2 read channel
    output logic                    read_addr_to_l2_valid_data,
    input  logic                    read_addr_to_l2_ready_data,
    output logic [ADDR_W-1:0]       read_addr_to_l2_data,
    output logic                    data_from_l2_ready_data,
    input  logic                    data_from_l2_valid_data,
    input  logic [L2_BUS_WIDTH-1:0] data_from_l2_data,
    // debug view of the controller state
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_BEAT = 3'd1,
        S_WB_WAIT = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    // Clearing the word-offset bits once at latch time lets base|cnt form
    // every beat address without an adder, so it can never leave the line.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [ADDR_W-1:0]  wb_base;
    logic [ADDR_W-1:0]  rd_base;
    logic               cnt_last;
    logic               accept;
    logic               wr_fire;
    logic               rd_fire;

    assign cnt_last  = (cnt == LAST_IDX);
    assign accept    = (state == S_IDLE) && req_valid;
    assign wr_fire   = (state == S_WB_BEAT) && write_to_l2_ready_data;
    assign rd_fire   = (state == S_RD_DATA) && data_from_l2_valid_data;
    assign state_dbg = state;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel outputs; every output is 0 unless its state drives it.
    always_comb begin
        state_nxt                  = state;
        req_ready                  = 1'b0;
        wb_index                   = '0;
        write_to_l2_valid_data     = 1'b0;
        write_addr_to_l2_data      = '0;
        data_to_l2_data            = '0;
        write_control_to_l2_data   = 1'b0;
        read_addr_to_l2_valid_data = 1'b0;
        read_addr_to_l2_data       = '0;
        data_from_l2_ready_data    = 1'b0;
        done                       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_wb ? S_WB_BEAT : S_RD_ADDR;
                end
            end
            S_WB_BEAT: begin
                write_to_l2_valid_data   = 1'b1;
                write_addr_to_l2_data    = wb_base | ADDR_W'(cnt);
                wb_index                 = cnt;
                data_to_l2_data          = wb_data;
                write_control_to_l2_data = cnt_last;
                if (write_to_l2_ready_data && cnt_last) begin
                    state_nxt = S_WB_WAIT;
                end
            end
            S_WB_WAIT: begin
                if (write_complete_data) begin
                    state_nxt = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                read_addr_to_l2_valid_data = 1'b1;
                read_addr_to_l2_data       = rd_base | ADDR_W'(cnt);
                if (read_addr_to_l2_ready_data) begin
                    state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                data_from_l2_ready_data = 1'b1;
                if (data_from_l2_valid_data) begin
                    state_nxt = cnt_last ? S_FIN : S_RD_ADDR;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Word counter and line base addresses captured at request acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wb_base <= '0;
            rd_base <= '0;
        end else if (accept) begin
            cnt     <= '0;
            wb_base <= req_wb_addr & LINE_MASK;
            rd_base <= req_read_addr & LINE_MASK;
        end else if (wr_fire || rd_fire) begin
            cnt     <= cnt + IDX_W'(1);
        end
    end

    // Registered fill return: one strobe per accepted L2 data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_valid <= 1'b0;
            fill_index <= '0;
            fill_data  <= '0;
        end else begin
            fill_valid <= rd_fire;
            if (rd_fire) begin
                fill_index <= cnt;
                fill_data  <= data_from_l2_data;
            end
        end
    end

endmodule
